// File: rtl/sink.sv
// Traffic sink/checker for one NoC router output port. It accepts flits under a
// programmable backpressure pattern, checks dest/id/ordering and keeps statistics.
module sink #(
  parameter int WIDTH         = 32,
  parameter int N             = 16,
  parameter int NUM_VC        = 2,
  parameter int N_ADDR_WIDTH  = $clog2(N),
  parameter int VC_ADDR_WIDTH = $clog2(NUM_VC),
  parameter int NODE          = 0,
  parameter int NUM_ID        = 16,
  parameter int STALL_EVERY   = 0,
  parameter int DONE_COUNT    = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         data_in,
  input  logic [VC_ADDR_WIDTH-1:0] vc_in,
  input  logic                     valid_in,
  output logic                     ready_out,
  output logic [31:0]              rx_count,
  output logic [15:0]              err_count,
  output logic                     err_flag,
  output logic [1:0]               err_code,
  output logic                     done
);

  localparam int CW   = WIDTH - 2*N_ADDR_WIDTH - 8;
  localparam int ID_W = (NUM_ID > 1) ? $clog2(NUM_ID) : 1;
  localparam int SW   = (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;

  localparam logic [SW-1:0]           S_LAST  = SW'((STALL_EVERY > 0) ? STALL_EVERY - 1 : 0);
  localparam logic [8:0]              ID_LIM  = 9'(NUM_ID);
  localparam logic [N_ADDR_WIDTH-1:0] MY_NODE = N_ADDR_WIDTH'(NODE);
  localparam logic [31:0]             DONE_TH = 32'(DONE_COUNT);

  logic [N_ADDR_WIDTH-1:0] src_node, dest;
  logic [7:0]              id;
  logic [CW-1:0]           cnt;
  logic [ID_W-1:0]         id_idx;
  logic [CW-1:0]           last_v;
  logic                    accept, dest_err, id_err, order_err, any_err;
  logic [1:0]              code;
  logic                    unused_src;

  logic              ready_q, ready_d;
  logic [SW-1:0]     phase_q, phase_d;
  logic [31:0]       rx_count_q, rx_count_d;
  logic [15:0]       err_count_q, err_count_d;
  logic              err_flag_q, err_flag_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [CW-1:0]     last_q [NUM_ID][NUM_VC];
  logic [CW-1:0]     last_d [NUM_ID][NUM_VC];

  always_comb begin
    {src_node, dest, id, cnt} = data_in;
    unused_src = ^src_node;
    id_idx     = id[ID_W-1:0];
    last_v     = last_q[id_idx][vc_in];
    accept     = valid_in && ready_q;
    dest_err   = (dest != MY_NODE);
    id_err     = ({1'b0, id} >= ID_LIM);
    // Never-seen entries hold 0, so c==0 is rejected there without a separate seen bit.
    order_err  = !id_err && !((cnt > last_v) || ((&last_v) && (cnt == '0)));
    if (dest_err)       code = 2'd1;
    else if (id_err)    code = 2'd2;
    else if (order_err) code = 2'd3;
    else                code = 2'd0;
    any_err = (code != 2'd0);
  end

  // phase_q is the stall position of the cycle being prepared, so ready_q drops
  // exactly in the cycle whose position is STALL_EVERY-1.
  always_comb begin
    if (STALL_EVERY == 0) begin
      ready_d = 1'b1;
      phase_d = '0;
    end else begin
      ready_d = (phase_q != S_LAST);
      phase_d = (phase_q == S_LAST) ? '0 : phase_q + 1'b1;
    end
  end

  always_comb begin
    rx_count_d  = rx_count_q;
    err_count_d = err_count_q;
    err_flag_d  = err_flag_q;
    err_code_d  = err_code_q;
    last_d      = last_q;
    if (accept) begin
      if (rx_count_q != '1) rx_count_d = rx_count_q + 1'b1;
      if (any_err) begin
        if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
        if (!err_flag_q) err_code_d = code;
        err_flag_d = 1'b1;
      end
      // Resync on every valid id, even when flagged, so one bad flit raises one error.
      if (!id_err) last_d[id_idx][vc_in] = cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q     <= 1'b0;
      phase_q     <= '0;
      rx_count_q  <= '0;
      err_count_q <= '0;
      err_flag_q  <= 1'b0;
      err_code_q  <= '0;
      last_q      <= '{default: '0};
    end else begin
      ready_q     <= ready_d;
      phase_q     <= phase_d;
      rx_count_q  <= rx_count_d;
      err_count_q <= err_count_d;
      err_flag_q  <= err_flag_d;
      err_code_q  <= err_code_d;
      last_q      <= last_d;
    end
  end

  always_comb begin
    ready_out = ready_q;
    rx_count  = rx_count_q;
    err_count = err_count_q;
    err_flag  = err_flag_q;
    err_code  = err_code_q;
    done      = (rx_count_q >= DONE_TH);
  end

endmodule

// File: tb/tb_sink.sv
// Directed bench for sink: u_a (NODE=5, no stalls, DONE_COUNT=4) and
// u_b (NODE=5, STALL_EVERY=4) share clock, reset and flit inputs.
module tb_sink;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic [0:0]  vc_in;
  logic        valid_in;

  logic        ready_a, err_flag_a, done_a;
  logic [31:0] rx_a;
  logic [15:0] err_a;
  logic [1:0]  code_a;
  logic        ready_b, err_flag_b, done_b;
  logic [31:0] rx_b;
  logic [15:0] err_b;
  logic [1:0]  code_b;

  int checks = 0;
  int errors = 0;
  logic [15:0] c5;
  logic        acc;

  always #5 clk = ~clk;

  sink #(.NODE(5), .STALL_EVERY(0), .DONE_COUNT(4)) u_a (
    .clk(clk), .rst(rst), .data_in(data_in), .vc_in(vc_in), .valid_in(valid_in),
    .ready_out(ready_a), .rx_count(rx_a), .err_count(err_a), .err_flag(err_flag_a),
    .err_code(code_a), .done(done_a)
  );

  sink #(.NODE(5), .STALL_EVERY(4), .DONE_COUNT(1000)) u_b (
    .clk(clk), .rst(rst), .data_in(data_in), .vc_in(vc_in), .valid_in(valid_in),
    .ready_out(ready_b), .rx_count(rx_b), .err_count(err_b), .err_flag(err_flag_b),
    .err_code(code_b), .done(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] dest, input logic [7:0] id, input logic vc,
                      input logic [15:0] c);
    data_in  = {4'd1, dest, id, c};
    vc_in    = vc;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; valid_in = 1'b0; data_in = '0; vc_in = '0;

    // T1: reset values, then ready the first cycle after reset
    repeat (3) @(posedge clk);
    #1;
    chk("t1_ready", 32'(ready_a), 0);
    chk("t1_rx", rx_a, 0);
    chk("t1_err", 32'(err_a), 0);
    chk("t1_flag", 32'(err_flag_a), 0);
    chk("t1_code", 32'(code_a), 0);
    chk("t1_done", 32'(done_a), 0);
    chk("t1_ready_b", 32'(ready_b), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t1_ready_after", 32'(ready_a), 1);

    // T2: in-order flits on id 2 vc 1
    send(4'd5, 8'd2, 1'b1, 16'd1);
    send(4'd5, 8'd2, 1'b1, 16'd2);
    send(4'd5, 8'd2, 1'b1, 16'd3);
    chk("t2_rx", rx_a, 3);
    chk("t2_err", 32'(err_a), 0);
    chk("t2_flag", 32'(err_flag_a), 0);
    chk("t2_done", 32'(done_a), 0);

    // T3: out-of-order then resync on id 2 vc 0
    send(4'd5, 8'd2, 1'b0, 16'd4);
    chk("t3_err_first", 32'(err_a), 0);
    send(4'd5, 8'd2, 1'b0, 16'd3);
    chk("t3_err", 32'(err_a), 1);
    chk("t3_code", 32'(code_a), 3);
    chk("t3_flag", 32'(err_flag_a), 1);
    send(4'd5, 8'd2, 1'b0, 16'd5);
    chk("t3_err_resync", 32'(err_a), 1);
    chk("t3_rx", rx_a, 6);
    chk("t3_done", 32'(done_a), 1);

    // T4: dest beats id; first code sticks; id boundaries
    do_reset();
    chk("t4_code_cleared", 32'(code_a), 0);
    send(4'd6, 8'd20, 1'b0, 16'd1);
    chk("t4_err1", 32'(err_a), 1);
    chk("t4_code1", 32'(code_a), 1);
    send(4'd5, 8'd20, 1'b0, 16'd1);
    chk("t4_err2", 32'(err_a), 2);
    chk("t4_code_sticky", 32'(code_a), 1);
    send(4'd5, 8'd15, 1'b0, 16'd1);
    chk("t4_id_max_ok", 32'(err_a), 2);
    send(4'd5, 8'd16, 1'b0, 16'd9);
    chk("t4_id_limit", 32'(err_a), 3);
    send(4'd5, 8'd15, 1'b0, 16'd1);
    chk("t4_equal_cnt", 32'(err_a), 4);
    send(4'd5, 8'd7, 1'b1, 16'd0);
    chk("t4_zero_unseen", 32'(err_a), 5);
    chk("t4_rx", rx_a, 6);

    // T5: backpressure 1,1,1,0 with a source that holds its flit while stalled
    do_reset();
    c5 = 16'd1;
    vc_in = 1'b0;
    valid_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      data_in = {4'd1, 4'd5, 8'd3, c5};
      chk($sformatf("t5_ready_%0d", i), 32'(ready_b), (i % 4 == 3) ? 0 : 1);
      acc = ready_b;
      @(posedge clk); #1;
      if (acc) c5 = c5 + 16'd1;
    end
    valid_in = 1'b0;
    chk("t5_rx", rx_b, 9);
    chk("t5_err", 32'(err_b), 0);

    // T6: counter wrap, done threshold, mid-stream reset
    do_reset();
    send(4'd5, 8'd4, 1'b1, 16'hffff);
    send(4'd5, 8'd4, 1'b1, 16'd0);
    send(4'd5, 8'd4, 1'b1, 16'd1);
    chk("t6_wrap_err", 32'(err_a), 0);
    chk("t6_done_3", 32'(done_a), 0);
    send(4'd5, 8'd4, 1'b1, 16'd2);
    chk("t6_done_4", 32'(done_a), 1);
    chk("t6_rx_4", rx_a, 4);
    data_in  = {4'd1, 4'd5, 8'd4, 16'd3};
    vc_in    = 1'b1;
    valid_in = 1'b1;
    rst      = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    chk("t6_rst_rx", rx_a, 0);
    chk("t6_rst_done", 32'(done_a), 0);
    chk("t6_rst_ready", 32'(ready_a), 0);
    chk("t6_rst_err", 32'(err_a), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    send(4'd5, 8'd4, 1'b1, 16'd1);
    chk("t6_table_cleared", 32'(err_a), 0);
    chk("t6_rx_after", rx_a, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
